// File: rtl/axi4lite_arbiter.sv
// Two-requester AXI4-Lite arbiter in front of a single shared AXI4-Lite slave.
// Only one transaction is in flight at a time. Requesters are served round-robin,
// and within the winning requester a write is served before a read.
module axi4lite_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [1:0]            s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [1:0]            s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // shared slave
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // status
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t state;
  logic   last_owner;
  logic   aw_done;
  logic   w_done;

  // request decode and round-robin pick
  logic wreq0, wreq1, req0, req1;
  logic win, win_wr;

  assign wreq0  = s0_axi_awvalid & s0_axi_wvalid;
  assign wreq1  = s1_axi_awvalid & s1_axi_wvalid;
  assign req0   = wreq0 | s0_axi_arvalid;
  assign req1   = wreq1 | s1_axi_arvalid;
  assign win    = (req0 & req1) ? ~last_owner : req1;
  assign win_wr = win ? wreq1 : wreq0;

  // owner-side view, selected by the registered grant
  logic                  owner;
  logic [ADDR_WIDTH-1:0] own_awaddr, own_araddr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;

  assign owner       = grant[1];
  assign own_awaddr  = owner ? s1_axi_awaddr  : s0_axi_awaddr;
  assign own_awvalid = owner ? s1_axi_awvalid : s0_axi_awvalid;
  assign own_wdata   = owner ? s1_axi_wdata   : s0_axi_wdata;
  assign own_wvalid  = owner ? s1_axi_wvalid  : s0_axi_wvalid;
  assign own_bready  = owner ? s1_axi_bready  : s0_axi_bready;
  assign own_araddr  = owner ? s1_axi_araddr  : s0_axi_araddr;
  assign own_arvalid = owner ? s1_axi_arvalid : s0_axi_arvalid;
  assign own_rready  = owner ? s1_axi_rready  : s0_axi_rready;

  // signals returned toward the owner before steering by grant
  logic                  ret_awready, ret_wready, ret_bvalid, ret_arready, ret_rvalid;
  logic [1:0]            ret_bresp;
  logic [DATA_WIDTH-1:0] ret_rdata;

  logic aw_hs, w_hs;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign busy  = (state != IDLE);

  // combinational forwarding between the owner and the slave for the current phase
  always_comb begin
    m_axi_awaddr  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    ret_awready   = 1'b0;
    ret_wready    = 1'b0;
    ret_bvalid    = 1'b0;
    ret_bresp     = 2'b00;
    ret_arready   = 1'b0;
    ret_rvalid    = 1'b0;
    ret_rdata     = '0;
    case (state)
      WR_ADDR: begin
        // a channel already accepted stays silent until the response phase
        m_axi_awvalid = own_awvalid & ~aw_done;
        m_axi_awaddr  = (own_awvalid & ~aw_done) ? own_awaddr : '0;
        m_axi_wvalid  = own_wvalid & ~w_done;
        m_axi_wdata   = (own_wvalid & ~w_done) ? own_wdata : '0;
        ret_awready   = m_axi_awready & ~aw_done;
        ret_wready    = m_axi_wready & ~w_done;
      end
      WR_RESP: begin
        m_axi_bready = own_bready;
        ret_bvalid   = m_axi_bvalid;
        ret_bresp    = m_axi_bresp;
      end
      RD_ADDR: begin
        m_axi_arvalid = own_arvalid;
        m_axi_araddr  = own_arvalid ? own_araddr : '0;
        ret_arready   = m_axi_arready;
      end
      RD_DATA: begin
        m_axi_rready = own_rready;
        ret_rvalid   = m_axi_rvalid;
        ret_rdata    = m_axi_rdata;
      end
      default: ;
    endcase
  end

  // steer returned signals to the granted requester; the other sees zeros
  assign s0_axi_awready = ret_awready & grant[0];
  assign s0_axi_wready  = ret_wready  & grant[0];
  assign s0_axi_bvalid  = ret_bvalid  & grant[0];
  assign s0_axi_bresp   = grant[0] ? ret_bresp : 2'b00;
  assign s0_axi_arready = ret_arready & grant[0];
  assign s0_axi_rvalid  = ret_rvalid  & grant[0];
  assign s0_axi_rdata   = grant[0] ? ret_rdata : '0;
  assign s1_axi_awready = ret_awready & grant[1];
  assign s1_axi_wready  = ret_wready  & grant[1];
  assign s1_axi_bvalid  = ret_bvalid  & grant[1];
  assign s1_axi_bresp   = grant[1] ? ret_bresp : 2'b00;
  assign s1_axi_arready = ret_arready & grant[1];
  assign s1_axi_rvalid  = ret_rvalid  & grant[1];
  assign s1_axi_rdata   = grant[1] ? ret_rdata : '0;

  // transaction FSM: arbitration, handshake tracking and round-robin history
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant <= win ? 2'b10 : 2'b01;
            state <= win_wr ? WR_ADDR : RD_ADDR;
          end
        end
        WR_ADDR: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid & m_axi_bready) begin
            state      <= IDLE;
            last_owner <= grant[1];
            grant      <= 2'b00;
          end
        end
        RD_ADDR: begin
          if (m_axi_arvalid & m_axi_arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (m_axi_rvalid & m_axi_rready) begin
            state      <= IDLE;
            last_owner <= grant[1];
            grant      <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4lite_arbiter.md
AXI4LITE_ARBITER -- requirements
Module: axi4lite_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of every wdata/rdata port.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the address width of every awaddr/araddr port.
REQ-003 s_axi_aclk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 s_axi_aresetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Requester ports, N in {0,1}; directions are as seen from the arbiter:
- s<N>_axi_awaddr  in  ADDR_WIDTH  write address.
- s<N>_axi_awvalid  in  1.
- s<N>_axi_awready  out  1.
- s<N>_axi_wdata  in  DATA_WIDTH.
- s<N>_axi_wvalid  in  1.
- s<N>_axi_wready  out  1.
- s<N>_axi_bresp  out  2.
- s<N>_axi_bvalid  out  1.
- s<N>_axi_bready  in  1.
- s<N>_axi_araddr  in  ADDR_WIDTH.
- s<N>_axi_arvalid  in  1.
- s<N>_axi_arready  out  1.
- s<N>_axi_rdata  out  DATA_WIDTH.
- s<N>_axi_rvalid  out  1.
- s<N>_axi_rready  in  1.
REQ-006 Shared-slave port m_axi_* SHALL carry the same 15 signals with directions mirrored; it connects to the team's AXI4-Lite slave.
- There is no rresp on any port.
REQ-007 grant  out  2  SHALL be a one-hot owner indication: bit N set means requester N owns the slave.
REQ-008 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-009 The FSM SHALL have five states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- Exactly one transaction SHALL be outstanding at a time.
REQ-010 Request definitions:
- wreq<N> = s<N>_axi_awvalid & s<N>_axi_wvalid.
- rreq<N> = s<N>_axi_arvalid.
- req<N> = wreq<N> | rreq<N>.
REQ-011 Arbitration in IDLE SHALL be round-robin on a registered last-owner bit (reset value 1, so requester 0 wins first).
- If both req0 and req1 are high, the requester that is not last-owner SHALL win.
REQ-012 Within the winning requester, a write SHALL take priority over a read.
- IDLE -> WR_ADDR on a write; IDLE -> RD_ADDR on a read.
- grant SHALL be registered at the same edge.
REQ-013 In IDLE all m_axi valid/ready outputs and all requester ready/valid outputs SHALL be 0.
- Forwarding SHALL begin one cycle after the request is sampled.
REQ-014 In WR_ADDR, signals SHALL be forwarded combinationally between the owner and m_axi:
- AW and W payload, valids and readies.
- Flags aw_done and w_done SHALL record each accepted handshake.
- Once a channel's flag is set, its m_axi valid SHALL be forced to 0.
REQ-015 WR_ADDR SHALL go to WR_RESP at the edge where both handshakes are complete, including when both complete in the same cycle.
- aw_done and w_done SHALL clear on that edge.
REQ-016 In WR_RESP:
- m_axi_bvalid/bresp SHALL be forwarded to the owner, and owner bready to m_axi_bready.
- On the bvalid & bready edge: state -> IDLE, last-owner <= owner, grant <= 00.
REQ-017 In RD_ADDR, araddr/arvalid/arready SHALL be forwarded.
- On the m_axi_arvalid & m_axi_arready edge: state -> RD_DATA.
REQ-018 In RD_DATA, rdata/rvalid SHALL be forwarded to the owner and owner rready to m_axi.
- On the rvalid & rready edge: state -> IDLE, last-owner updated, grant <= 00.
REQ-019 The non-owner SHALL see all of its ready and valid outputs at 0, and its payload outputs at 0, for the whole transaction.
- Its requests SHALL be held pending, never dropped.
REQ-020 m_axi payload outputs SHALL be 0 whenever the corresponding m_axi valid is 0.
REQ-021 A transaction SHALL never be aborted by the arbiter.
- If the owner deasserts valid mid-transaction, the state SHALL hold.
REQ-022 The arbiter SHALL NOT modify bresp or rdata values.

Reset
REQ-023 While s_axi_aresetn is low, the following SHALL hold immediately and asynchronously:
- state = IDLE, grant = 00, busy = 0, last-owner = 1, aw_done = 0, w_done = 0.
- All m_axi and s<N> valid/ready outputs = 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction.
- After release, the first arbitration SHALL favour requester 0.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single write: requester 0 writes awaddr 0x04, wdata 0xDEADBEEF -> grant = 01 one cycle later; slave receives addr 0x04 and data 0xDEADBEEF; s0 sees bvalid with bresp 00; then IDLE.
- Contention: s0 and s1 both issue a read in the same cycle after reset -> s0 served first, then s1; grant sequence 01, 00, 10.
- Fairness: s0 and s1 request continuously -> grants alternate 01/10 across 4 transactions; no requester is served twice in a row.
- Split write handshake: slave accepts AW in cycle k and W in cycle k+2 -> m_axi_awvalid drops after cycle k; WR_RESP is entered at edge k+2; exactly one write occurs.
- Back-pressure: bready held low 5 cycles and rready low 3 cycles -> state holds; the s1 request stays pending, and s1 ready/valid outputs stay 0 throughout.
- Reset during RD_DATA: aresetn pulsed low -> all outputs 0 the same cycle; a subsequent s0/s1 tie grants s0.
